// File: rtl/chipset_nregions_ws.sv
// N-region memory-map decoder and bus controller with per-region wait states.
module chipset_nregions_ws #(
   parameter int unsigned           NREG     = 4,
   parameter int unsigned           AW       = 32,
   parameter int unsigned           DW       = 32,
   parameter logic [NREG*AW-1:0]    REG_BASE = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
   parameter logic [NREG*AW-1:0]    REG_MASK = {4{32'hFFFF_0000}},
   parameter logic [NREG*4-1:0]     REG_WAIT = {4{4'd1}},
   parameter logic [NREG-1:0]       REG_RO   = 4'b0011
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic                 we,
   input  logic [AW-1:0]        addr,
   input  logic [DW-1:0]        wd,
   output logic [DW-1:0]        rdata,
   output logic                 ready,
   output logic                 err,
   output logic [NREG-1:0]      sel_o,
   output logic [NREG-1:0]      we_o,
   output logic [AW-1:0]        addr_o,
   output logic [DW-1:0]        wd_o,
   input  logic [NREG*DW-1:0]   rd_i
);

   localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      ERR    = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   cur;
   logic            first;

   logic [AW-1:0]   base_a [NREG];
   logic [AW-1:0]   mask_a [NREG];
   logic [CW-1:0]   wait_a [NREG];
   logic [DW-1:0]   rd_a   [NREG];

   logic            hit_c;
   logic [IW-1:0]   hit_idx_c;
   logic            deny_c;

   // Unpack the per-region parameter vectors and read-data bus.
   for (genvar g = 0; g < NREG; g++) begin : g_unpack
      assign base_a[g] = REG_BASE[g*AW +: AW];
      assign mask_a[g] = REG_MASK[g*AW +: AW];
      assign wait_a[g] = REG_WAIT[g*CW +: CW];
      assign rd_a[g]   = rd_i[g*DW +: DW];
   end

   // Address decode; scanning downward lets the lowest matching index win.
   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if ((addr & mask_a[i]) == base_a[i]) begin
            hit_c     = 1'b1;
            hit_idx_c = IW'(i);
         end
      end
      deny_c = !hit_c || (we && REG_RO[hit_idx_c]);
   end

   // Controller FSM with registered bus outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         cur    <= '0;
         first  <= 1'b0;
         rdata  <= '0;
         ready  <= 1'b0;
         err    <= 1'b0;
         sel_o  <= '0;
         we_o   <= '0;
         addr_o <= '0;
         wd_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (deny_c) begin
                     state <= ERR;
                  end else begin
                     state  <= ACCESS;
                     sel_o  <= NREG'(1) << hit_idx_c;
                     we_o   <= we ? (NREG'(1) << hit_idx_c) : '0;
                     addr_o <= addr & ~mask_a[hit_idx_c];
                     wd_o   <= wd;
                     cnt    <= wait_a[hit_idx_c];
                     cur    <= hit_idx_c;
                     first  <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // First cycle only carries the write strobe; wait counting follows.
               we_o <= '0;
               if (first) begin
                  first <= 1'b0;
               end else if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  rdata <= rd_a[cur];
                  ready <= 1'b1;
                  sel_o <= '0;
                  state <= RESP;
               end
            end
            ERR: begin
               rdata <= '0;
               ready <= 1'b1;
               err   <= 1'b1;
               state <= RESP;
            end
            RESP: begin
               ready <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chipset_nregions_ws.sv
// Randomized bench for chipset_nregions_ws against a table-driven decode model.
module tb_chipset_nregions_ws;

   localparam int unsigned NREG = 4;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;

   // Region 1 overlaps the low half of region 3 and wins by priority.
   localparam logic [NREG*AW-1:0] P_BASE = {32'h0003_0000, 32'h0002_0000, 32'h0003_0000, 32'h0000_0000};
   localparam logic [NREG*AW-1:0] P_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_8000, 32'hFFFF_0000};
   localparam logic [NREG*4-1:0]  P_WAIT = {4'd2, 4'd1, 4'd3, 4'd0};
   localparam logic [NREG-1:0]    P_RO   = 4'b0011;

   // Reference tables, region 0 first.
   logic [31:0] m_base [NREG] = '{32'h0000_0000, 32'h0003_0000, 32'h0002_0000, 32'h0003_0000};
   logic [31:0] m_mask [NREG] = '{32'hFFFF_0000, 32'hFFFF_8000, 32'hFFFF_0000, 32'hFFFF_0000};
   int          m_wait [NREG] = '{0, 3, 1, 2};
   bit          m_ro   [NREG] = '{1'b1, 1'b1, 1'b0, 1'b0};

   logic                clk;
   logic                reset;
   logic                req;
   logic                we;
   logic [AW-1:0]       addr;
   logic [DW-1:0]       wd;
   logic [DW-1:0]       rdata;
   logic                ready;
   logic                err;
   logic [NREG-1:0]     sel_o;
   logic [NREG-1:0]     we_o;
   logic [AW-1:0]       addr_o;
   logic [DW-1:0]       wd_o;
   logic [NREG*DW-1:0]  rd_i;

   int checks   = 0;
   int failures = 0;

   chipset_nregions_ws #(
      .NREG(NREG), .AW(AW), .DW(DW),
      .REG_BASE(P_BASE), .REG_MASK(P_MASK), .REG_WAIT(P_WAIT), .REG_RO(P_RO)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wd(wd),
      .rdata(rdata), .ready(ready), .err(err), .sel_o(sel_o), .we_o(we_o),
      .addr_o(addr_o), .wd_o(wd_o), .rd_i(rd_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic w, output int r, output bit e);
      r = -1;
      for (int i = 0; i < NREG; i++)
         if (r < 0 && (a & m_mask[i]) == m_base[i]) r = i;
      if (r < 0) e = 1'b1;
      else       e = w && m_ro[r];
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rdata"}, 64'(rdata), 64'd0);
      check({tag, "_ready"}, 64'(ready), 64'd0);
      check({tag, "_err"},   64'(err),   64'd0);
      check({tag, "_sel"},   64'(sel_o), 64'd0);
      check({tag, "_we"},    64'(we_o),  64'd0);
      check({tag, "_addr"},  64'(addr_o), 64'd0);
      check({tag, "_wd"},    64'(wd_o),  64'd0);
   endtask

   // One complete access; called on a negedge with the controller idle.
   task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
      int r; bit e; int lat;
      logic [NREG-1:0] oh;
      logic [DW-1:0]   exp_rd;
      model(a, w, r, e);
      lat = e ? 1 : 2 + m_wait[r];
      oh  = e ? '0 : (NREG'(1) << r);
      for (int k = 0; k < NREG; k++) rd_i[k*DW +: DW] = $urandom;
      exp_rd = e ? '0 : rd_i[r*DW +: DW];
      req = 1'b1; we = w; addr = a; wd = d;
      @(posedge clk);
      @(negedge clk);
      if (!e) begin
         check("addr_o", 64'(addr_o), 64'(a & ~m_mask[r]));
         check("wd_o",   64'(wd_o),   64'(d));
      end
      for (int j = 0; j <= lat; j++) begin
         if (j > 0) @(negedge clk);
         check("we_o",  64'(we_o),  (j == 0 && w && !e) ? 64'(oh) : 64'd0);
         check("sel_o", 64'(sel_o), (j < lat) ? 64'(oh) : 64'd0);
         check("ready", 64'(ready), 64'(j == lat));
         if (j == lat) begin
            check("err", 64'(err), 64'(e));
            if (e || !w) check("rdata", 64'(rdata), 64'(exp_rd));
         end
      end
      req = 1'b0;
      @(negedge clk);
      check("ready_drop", 64'(ready), 64'd0);
      check("err_drop",   64'(err),   64'd0);
   endtask

   initial begin
      logic [15:0] hi;
      req = 1'b0; we = 1'b0; addr = '0; wd = '0; rd_i = '0;
      reset = 1'b0;

      // Held in reset while inputs wiggle.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req = ~req; we = ~we; addr = $urandom; wd = $urandom;
      end
      @(negedge clk);
      check_idle_outputs("rst");
      req = 1'b0; we = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(ready), 64'd0);
      check("post_rst_sel",   64'(sel_o), 64'd0);

      // Directed corner accesses.
      run_txn(32'h0002_0010, 1'b0, 32'h0);            // region 2 read, W=1
      run_txn(32'h0003_8004, 1'b1, 32'h0000_00A5);    // region 3 write
      run_txn(32'h0000_0008, 1'b1, 32'h1111_2222);    // read-only write
      run_txn(32'h0005_0000, 1'b0, 32'h0);            // unmapped
      run_txn(32'h0003_0000, 1'b0, 32'h0);            // overlap, region 1 wins, W=3
      run_txn(32'h0000_0040, 1'b0, 32'h0);            // W=0 region

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0: hi = 16'h0000;
            1: hi = 16'h0002;
            2: hi = 16'h0003;
            3: hi = 16'h0003;
            4: hi = 16'h0005;
            default: hi = 16'($urandom);
         endcase
         run_txn({hi, 16'($urandom)}, 1'($urandom), $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset during a read access on the W=3 region.
      for (int k = 0; k < NREG; k++) rd_i[k*DW +: DW] = $urandom;
      req = 1'b1; we = 1'b0; addr = 32'h0003_0010; wd = '0;
      @(posedge clk);
      @(negedge clk);
      check("mid_sel", 64'(sel_o), 64'h2);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_idle_outputs("mid_rd");
      req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mid_rd_ready", 64'(ready), 64'd0);
         check("mid_rd_we",    64'(we_o),  64'd0);
      end

      // Reset while the write strobe is active.
      req = 1'b1; we = 1'b1; addr = 32'h0003_8000; wd = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 check("mid_wr_strobe", 64'(we_o), 64'h8);
      #1 reset = 1'b0;
      #1 check_idle_outputs("mid_wr");
      req = 1'b0; we = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mid_wr_ready", 64'(ready), 64'd0);
         check("mid_wr_we",    64'(we_o),  64'd0);
      end

      // Normal access still works afterwards.
      run_txn(32'h0002_0020, 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
